// File: rtl/montgomery_pkg.sv
// Shared constants and helpers for the parametrised Montgomery multiplier.
// State encodings are plain localparams so older tools and netlists can read them.
package montgomery_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulator width: one bit of headroom above t < 2m plus one for the t + b + m sum.
  function automatic int unsigned t_width(input int unsigned n);
    return n + 2;
  endfunction

endpackage

// File: rtl/montgomery_step.sv
// One combinational radix-2 Montgomery step: t' = (t + a_i*b + q*m) / 2.
module montgomery_step
  import montgomery_pkg::*;
#(
  parameter int unsigned N = 1024
) (
  input  logic [t_width(N)-1:0] i_t,
  input  logic [N-1:0]          i_b,
  input  logic [N-1:0]          i_m,
  input  logic                  i_a_bit,
  output logic [t_width(N)-1:0] o_t_next
);

  localparam int unsigned TW = t_width(N);

  logic [TW-1:0] w_add_b;
  logic [TW-1:0] w_add_m;

  always_comb begin
    w_add_b  = i_t + (i_a_bit ? {{(TW-N){1'b0}}, i_b} : {TW{1'b0}});
    // Adding m when t is odd makes the sum even, so the shift is exact.
    w_add_m  = w_add_b + (w_add_b[0] ? {{(TW-N){1'b0}}, i_m} : {TW{1'b0}});
    o_t_next = {1'b0, w_add_m[TW-1:1]};
  end

endmodule

// File: rtl/montgomery_mul_param.sv
// Iterative Montgomery multiplier: result = a*b*2^-N mod m, K radix-2 steps per clock,
// with an optional lazy mode that leaves the result in [0, 2m).
module montgomery_mul_param
  import montgomery_pkg::*;
#(
  parameter int unsigned N = 1024,
  parameter int unsigned K = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         in_lazy,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N:0]   result,
  output logic         done,
  output logic         busy
);

  localparam int unsigned TW = t_width(N);
  localparam int unsigned NK = N / K;
  localparam int unsigned CW = (clog2(NK) == 0) ? 1 : clog2(NK);
  localparam logic [CW-1:0] CNT_LAST = CW'(NK - 1);

  logic [1:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_m;
  logic          r_lazy;
  logic [TW-1:0] r_t;
  logic [CW-1:0] r_cnt;
  logic          r_prime;
  logic [N:0]    r_result;
  logic          r_done;
  logic          r_busy;

  logic [TW-1:0] w_chain [K+1];
  logic [TW-1:0] w_diff;
  logic          w_ge;
  logic [N:0]    w_reduced;

  assign w_chain[0] = r_t;

  for (genvar g = 0; g < K; g++) begin : g_step
    montgomery_step #(
      .N(N)
    ) u_step (
      .i_t     (w_chain[g]),
      .i_b     (r_b),
      .i_m     (r_m),
      .i_a_bit (r_a[g]),
      .o_t_next(w_chain[g+1])
    );
  end

  always_comb begin
    w_diff    = r_t - {{(TW-N){1'b0}}, r_m};
    w_ge      = (r_t >= {{(TW-N){1'b0}}, r_m});
    w_reduced = w_ge ? w_diff[N:0] : r_t[N:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_lazy   <= 1'b0;
      r_t      <= '0;
      r_cnt    <= '0;
      r_prime  <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_m     <= in_m;
            r_lazy  <= in_lazy;
            r_t     <= '0;
            r_cnt   <= '0;
            r_prime <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          // First ITER cycle only settles the freshly latched operands into the step chain;
          // this keeps the controller-visible latency at N/K+2 edges.
          if (r_prime) begin
            r_prime <= 1'b0;
          end else begin
            r_t   <= w_chain[K];
            r_a   <= r_a >> K;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              r_state <= S_SUB;
            end
          end
        end
        S_SUB: begin
          r_result <= r_lazy ? r_t[N:0] : w_reduced;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = r_busy;

endmodule

// File: doc/montgomery_mul_param.md
Name: montgomery_mul_param

Overview:
Parametrised iterative Montgomery modular multiplier computing result = a*b*2^-N mod m.
- Successor to the fixed-width bit-serial multiplier; generalised in operand width N and bits-per-cycle K.
- Adds a lazy-reduction mode that skips the final subtraction, plus a busy indicator.
- Sits beneath the modular-exponentiation controller, which issues one start per multiplication and waits on done.

Parameters:
N, 1024, operand/modulus width in bits; N >= 4.
K, 1, radix-2 steps unrolled per clock; N % K == 0 and 1 <= K <= 8.

Ports:
clk  input  1  rising-edge clock.
resetn  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE or DONE.
in_lazy  input  1  1 = skip final subtraction; sampled with start.
in_a  input  N  multiplicand; requires in_a < in_m.
in_b  input  N  multiplier; requires in_b < in_m.
in_m  input  N  modulus; requires odd and in_m < 2^N.
result  output  N+1  product; < m (normal) or < 2m (lazy).
done  output  1  high from completion until the next accepted start.
busy  output  1  high while an operation is in flight.

Behaviour:
- Reset: asynchronous on resetn low. State=IDLE; result, done, busy, t and all operand registers = 0. Reset during ITER/SUB aborts the operation; no done is produced.
- FSM states: IDLE, ITER, SUB, DONE.
- IDLE or DONE with start=1: latch in_a, in_b, in_m and in_lazy. Clear t (N+2 bits) and counter. Clear done, set busy, go to ITER.
- ITER: each cycle applies K radix-2 steps to t, taking bits of a LSB-first from a shift register:
  - t += a_i ? b : 0
  - if t[0], t += m
  - t >>= 1
  - Counter counts to N/K-1; on the last ITER cycle go to SUB.
  - Invariant: t < 2m, so t fits in N+1 bits; the N+2-bit width covers the intermediate sum.
- SUB (exactly one cycle):
  - Normal mode: result = (t >= m) ? t - m : t.
  - Lazy mode: result = t (N+1 bits).
  - Then set done=1, busy=0, go to DONE.
- Latency: start accepted at edge 0; done rises at edge N/K+2; result is valid on the same edge. Example: N=1024, K=1 gives 1026 cycles.
- DONE: result and done hold until start. A start in DONE behaves as a start in IDLE, so done drops on the next edge (back-to-back operation).
- start while busy=1 is ignored; latched operands are unaffected.
- Operand inputs may change freely after the accepting edge.
- Inputs violating the a,b < m or odd-m preconditions give an undefined result but must not hang: done still arrives after N/K+2 cycles.
- Unrolled K steps form one combinational chain. No multi-cycle paths are assumed.

Decomposition:
- Package montgomery_pkg holds:
  - state enum (IDLE, ITER, SUB, DONE)
  - function clog2, used for counter width = clog2(N/K)
  - localparam TW = N+2
- Sub-module montgomery_step: combinational single radix-2 step.
  - Inputs: t[TW], b[N], m[N], a_bit.
  - Output: t_next[TW].
  - Top instantiates K copies in a generate chain.

Test Plan:
- N=8, K=1, a=5, b=7, m=13, lazy=0 -> result=1, done rises exactly 10 cycles after the start edge, busy high for cycles 1..9.
- N=4, K=1, a=14, b=14, m=15: lazy=1 -> result=0x10 (16 >= m, unreduced); repeat with lazy=0 -> result=1; done after 6 cycles in both cases.
- N=8, K=2, a=5, b=7, m=13 -> result=1 with done after 6 cycles; K=4 -> result=1 with done after 4 cycles.
- N=8, K=1: assert start again at cycle 4 with a=1, b=1 -> ignored, result=1 at cycle 10. Then assert start on the done cycle with a=12, b=12, m=13 -> done drops next edge, result=3 ten cycles later.
- N=8, K=1: pull resetn low at cycle 5 mid-ITER -> result=0, done=0, busy=0 immediately (asynchronous); a new start after release -> correct result with full latency.
- N=1024, K=1 and K=4: 200 random odd m with MSB set and random a,b < m, both modes -> match the golden model (a*b*R^-1 mod m; lazy result ≡ golden mod m and < 2m).
